// File: rtl/rggen_apb_bit_field_bridge.sv
// APB slave to single bit-field access bridge, one register address.
// Define RGGEN_APB_BIT_FIELD_BRIDGE_PSTRB_EN to derive write masks from i_pstrb.
module rggen_apb_bit_field_bridge #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0] REGISTER_ADDRESS = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_psel,
  input  logic                      i_penable,
  input  logic [ADDRESS_WIDTH-1:0]  i_paddr,
  input  logic                      i_pwrite,
  input  logic [DATA_WIDTH-1:0]     i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]   i_pstrb,
  output logic                      o_pready,
  output logic [DATA_WIDTH-1:0]     o_prdata,
  output logic                      o_pslverr,
  output logic                      o_bf_valid,
  output logic [WIDTH-1:0]          o_bf_read_mask,
  output logic [WIDTH-1:0]          o_bf_write_mask,
  output logic [WIDTH-1:0]          o_bf_write_data,
  input  logic [WIDTH-1:0]          i_bf_read_data
);
  localparam int LSB = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_e;

  state_e           r_state;
  logic             r_hit;
  logic             r_write;
  logic             r_valid;
  logic             r_pready;
  logic             r_pslverr;
  logic [WIDTH-1:0] r_rmask;
  logic [WIDTH-1:0] r_wmask;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rdata;

  logic             w_setup;
  logic             w_access;
  logic             w_hit;
  logic             w_strobe;
  logic [WIDTH-1:0] w_wmask;
  logic             w_unused;

  assign w_setup  = i_psel & ~i_penable;
  assign w_access = i_psel & i_penable;
  assign w_hit    = i_paddr[ADDRESS_WIDTH-1:LSB]
                 == REGISTER_ADDRESS[ADDRESS_WIDTH-1:LSB];
  assign w_unused = ^{i_paddr, i_pwdata, i_pstrb};

`ifdef RGGEN_APB_BIT_FIELD_BRIDGE_PSTRB_EN
  for (genvar g = 0; g < WIDTH; g++) begin : g_wmask
    assign w_wmask[g] = i_pstrb[g/8];
  end
`else
  assign w_wmask = '1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_hit     <= 1'b0;
      r_write   <= 1'b0;
      r_valid   <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_rmask   <= '0;
      r_wmask   <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_state <= ACCESS;
            r_hit   <= w_hit;
            r_write <= i_pwrite;
            r_valid <= w_hit;
            r_rmask <= (w_hit & ~i_pwrite) ? '1 : '0;
            r_wmask <= (w_hit & i_pwrite) ? w_wmask : '0;
            r_wdata <= (w_hit & i_pwrite) ? i_pwdata[WIDTH-1:0] : '0;
          end
        end
        ACCESS: begin
          r_valid <= 1'b0;
          r_rmask <= '0;
          r_wmask <= '0;
          r_wdata <= '0;
          if (w_access) begin
            r_state   <= RESPOND;
            r_pready  <= 1'b1;
            r_pslverr <= ~r_hit;
            // value seen during the strobe, before any read side effect
            r_rdata   <= (r_hit & ~r_write) ? i_bf_read_data : '0;
          end else begin
            r_state <= IDLE;
          end
        end
        RESPOND: begin
          r_state   <= IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_rdata   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // a master abandoning the access phase cancels the prepared strobe
  assign w_strobe        = r_valid & i_psel & i_penable;
  assign o_bf_valid      = w_strobe;
  assign o_bf_read_mask  = r_rmask & {WIDTH{w_strobe}};
  assign o_bf_write_mask = r_wmask & {WIDTH{w_strobe}};
  assign o_bf_write_data = r_wdata & {WIDTH{w_strobe}};

  assign o_pready  = r_pready;
  assign o_pslverr = r_pslverr;
  assign o_prdata  = DATA_WIDTH'(r_rdata);

endmodule

// File: tb/tb_rggen_apb_bit_field_bridge.sv
// Bench for rggen_apb_bit_field_bridge: transfer-level model plus literals.
// Instance 0 uses WIDTH=8, instance 1 uses WIDTH=16.
module tb_rggen_apb_bit_field_bridge;
  localparam int NC = 256;
  localparam logic [7:0] RA = 8'h10;

  logic clk = 1'b0;
  logic rst_n;
  logic psel8, psel16, penable, pwrite;
  logic [7:0] paddr;
  logic [31:0] pwdata;
  logic [3:0] pstrb;

  logic rdy8, err8, v8;
  logic [31:0] prd8;
  logic [7:0] rm8, wm8, wd8;
  logic [7:0] fld8;

  logic rdy16, err16, v16;
  logic [31:0] prd16;
  logic [15:0] rm16, wm16, wd16;
  logic [15:0] fld16;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit done = 0;

  logic        ev   [2][NC];
  logic [15:0] erm  [2][NC];
  logic [15:0] ewm  [2][NC];
  logic [15:0] ewd  [2][NC];
  logic        erdy [2][NC];
  logic        eerr [2][NC];
  logic [31:0] eprd [2][NC];

  logic        s1v;
  logic [15:0] s1rm, s1wm, s1wd;
  logic        s2rdy, s2err;
  logic [31:0] s2prd;

  rggen_apb_bit_field_bridge #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(32), .WIDTH(8),
    .REGISTER_ADDRESS(RA)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_psel(psel8), .i_penable(penable),
    .i_paddr(paddr), .i_pwrite(pwrite),
    .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(rdy8), .o_prdata(prd8), .o_pslverr(err8),
    .o_bf_valid(v8), .o_bf_read_mask(rm8),
    .o_bf_write_mask(wm8), .o_bf_write_data(wd8),
    .i_bf_read_data(fld8)
  );

  rggen_apb_bit_field_bridge #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(32), .WIDTH(16),
    .REGISTER_ADDRESS(RA)
  ) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_psel(psel16), .i_penable(penable),
    .i_paddr(paddr), .i_pwrite(pwrite),
    .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(rdy16), .o_prdata(prd16), .o_pslverr(err16),
    .o_bf_valid(v16), .o_bf_read_mask(rm16),
    .o_bf_write_mask(wm16), .o_bf_write_data(wd16),
    .i_bf_read_data(fld16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign fld16 = 16'h1357;

  // environment field for instance 0: read-set, masked write
  initial fld8 = 8'h5A;
  always @(posedge clk) begin
    if (v8) begin
      if (rm8 != 8'h00) fld8 <= 8'hFF;
      else fld8 <= (fld8 & ~wm8) | (wd8 & wm8);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done && cyc < NC) begin
      chk("m_valid8",  {31'd0, v8},    {31'd0, ev[0][cyc]});
      chk("m_rmask8",  {24'd0, rm8},   {16'd0, erm[0][cyc]});
      chk("m_wmask8",  {24'd0, wm8},   {16'd0, ewm[0][cyc]});
      chk("m_wdata8",  {24'd0, wd8},   {16'd0, ewd[0][cyc]});
      chk("m_pready8", {31'd0, rdy8},  {31'd0, erdy[0][cyc]});
      chk("m_slverr8", {31'd0, err8},  {31'd0, eerr[0][cyc]});
      chk("m_prdata8", prd8,           eprd[0][cyc]);
      chk("m_valid16", {31'd0, v16},   {31'd0, ev[1][cyc]});
      chk("m_rmask16", {16'd0, rm16},  {16'd0, erm[1][cyc]});
      chk("m_wmask16", {16'd0, wm16},  {16'd0, ewm[1][cyc]});
      chk("m_wdata16", {16'd0, wd16},  {16'd0, ewd[1][cyc]});
      chk("m_pready16", {31'd0, rdy16}, {31'd0, erdy[1][cyc]});
      chk("m_slverr16", {31'd0, err16}, {31'd0, eerr[1][cyc]});
      chk("m_prdata16", prd16,          eprd[1][cyc]);
    end
  end

  // mode: 0 normal, 1 psel dropped in access, 2 reset pulsed in access
  task automatic xfer(input int d, input logic [7:0] a, input logic w,
                      input logic [31:0] wd, input logic [3:0] st,
                      input int mode);
    int n;
    logic hit;
    logic [15:0] full, m, rd;
    paddr = a;
    pwrite = w;
    pwdata = wd;
    pstrb = st;
    penable = 1'b0;
    if (d == 0) psel8 = 1'b1;
    else psel16 = 1'b1;
    n = cyc;
    hit = (a >> 2) == (RA >> 2);
    full = (d == 0) ? 16'h00FF : 16'hFFFF;
    rd = (d == 0) ? {8'h00, fld8} : fld16;
`ifdef RGGEN_APB_BIT_FIELD_BRIDGE_PSTRB_EN
    for (int i = 0; i < 16; i++) m[i] = st[i/8];
    m = m & full;
`else
    m = full;
`endif
    if (mode == 0 && n + 2 < NC) begin
      ev[d][n+1]   = hit;
      erm[d][n+1]  = (hit && !w) ? full : 16'h0;
      ewm[d][n+1]  = (hit && w) ? m : 16'h0;
      ewd[d][n+1]  = (hit && w) ? (wd[15:0] & full) : 16'h0;
      erdy[d][n+2] = 1'b1;
      eerr[d][n+2] = !hit;
      eprd[d][n+2] = (hit && !w) ? {16'h0, rd} : 32'h0;
    end
    @(posedge clk); #1;
    if (mode == 1) begin
      psel8 = 1'b0;
      psel16 = 1'b0;
    end else begin
      penable = 1'b1;
    end
    if (mode == 2) rst_n = 1'b0;
    @(negedge clk);
    s1v  = (d == 0) ? v8 : v16;
    s1rm = (d == 0) ? {8'h0, rm8} : rm16;
    s1wm = (d == 0) ? {8'h0, wm8} : wm16;
    s1wd = (d == 0) ? {8'h0, wd8} : wd16;
    @(posedge clk); #1;
    if (mode == 2) begin
      rst_n = 1'b1;
      psel8 = 1'b0;
      psel16 = 1'b0;
      penable = 1'b0;
    end
    @(negedge clk);
    s2rdy = (d == 0) ? rdy8 : rdy16;
    s2err = (d == 0) ? err8 : err16;
    s2prd = (d == 0) ? prd8 : prd16;
    @(posedge clk); #1;
    psel8 = 1'b0;
    psel16 = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) begin
        ev[d][c] = 1'b0;
        erm[d][c] = '0;
        ewm[d][c] = '0;
        ewd[d][c] = '0;
        erdy[d][c] = 1'b0;
        eerr[d][c] = 1'b0;
        eprd[d][c] = '0;
      end
    end
    rst_n = 1'b0;
    psel8 = 1'b1;
    psel16 = 1'b1;
    penable = 1'b0;
    paddr = RA;
    pwrite = 1'b0;
    pwdata = '0;
    pstrb = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_pready", {31'd0, rdy8}, 32'd0);
    chk("rst_valid", {31'd0, v8}, 32'd0);
    chk("rst_prdata", prd8, 32'd0);
    @(posedge clk); #1;
    psel8 = 1'b0;
    psel16 = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_pready", {31'd0, rdy8}, 32'd0);
    @(posedge clk); #1;

    xfer(0, 8'h10, 1'b0, 32'h0, 4'hF, 0);
    chk("rd_valid", {31'd0, s1v}, 32'd1);
    chk("rd_rmask", {16'd0, s1rm}, 32'h00FF);
    chk("rd_wmask", {16'd0, s1wm}, 32'h0);
    chk("rd_pready", {31'd0, s2rdy}, 32'd1);
    chk("rd_prdata", s2prd, 32'h0000005A);
    chk("rd_slverr", {31'd0, s2err}, 32'd0);

    xfer(0, 8'h10, 1'b1, 32'h123456C3, 4'hF, 0);
    chk("wr_valid", {31'd0, s1v}, 32'd1);
    chk("wr_wmask", {16'd0, s1wm}, 32'h00FF);
    chk("wr_wdata", {16'd0, s1wd}, 32'h00C3);
    chk("wr_rmask", {16'd0, s1rm}, 32'h0);
    chk("wr_pready", {31'd0, s2rdy}, 32'd1);
    chk("wr_prdata", s2prd, 32'h0);
    chk("wr_slverr", {31'd0, s2err}, 32'd0);

    xfer(0, 8'h14, 1'b0, 32'h0, 4'hF, 0);
    chk("miss_valid", {31'd0, s1v}, 32'd0);
    chk("miss_pready", {31'd0, s2rdy}, 32'd1);
    chk("miss_slverr", {31'd0, s2err}, 32'd1);
    chk("miss_prdata", s2prd, 32'h0);

    xfer(0, 8'h13, 1'b0, 32'h0, 4'hF, 0);
    chk("b2b_rd_prdata", s2prd, 32'h000000C3);
    xfer(0, 8'h10, 1'b1, 32'h00000077, 4'hF, 0);
    chk("b2b_wr_valid", {31'd0, s1v}, 32'd1);
    xfer(0, 8'h10, 1'b0, 32'h0, 4'hF, 0);
    chk("b2b_readback", s2prd, 32'h00000077);

    xfer(0, 8'h10, 1'b0, 32'h0, 4'hF, 1);
    chk("drop_valid", {31'd0, s1v}, 32'd0);
    chk("drop_pready", {31'd0, s2rdy}, 32'd0);
    xfer(0, 8'h10, 1'b0, 32'h0, 4'hF, 0);
    chk("drop_next_prdata", s2prd, 32'h000000FF);

    xfer(0, 8'h10, 1'b1, 32'h000000AA, 4'hF, 2);
    chk("rstm_valid", {31'd0, s1v}, 32'd0);
    chk("rstm_pready", {31'd0, s2rdy}, 32'd0);
    xfer(0, 8'h10, 1'b0, 32'h0, 4'hF, 0);
    chk("rstm_field_kept", s2prd, 32'h000000FF);

    xfer(0, 8'h10, 1'b1, 32'h00000000, 4'h0, 0);
    chk("strb0_valid", {31'd0, s1v}, 32'd1);
`ifdef RGGEN_APB_BIT_FIELD_BRIDGE_PSTRB_EN
    chk("strb0_wmask", {16'd0, s1wm}, 32'h0000);
`else
    chk("strb0_wmask", {16'd0, s1wm}, 32'h00FF);
`endif

    xfer(1, 8'h10, 1'b1, 32'h0000ABCD, 4'b0010, 0);
    chk("w16_valid", {31'd0, s1v}, 32'd1);
`ifdef RGGEN_APB_BIT_FIELD_BRIDGE_PSTRB_EN
    chk("w16_wmask", {16'd0, s1wm}, 32'hFF00);
`else
    chk("w16_wmask", {16'd0, s1wm}, 32'hFFFF);
`endif
    chk("w16_wdata", {16'd0, s1wd}, 32'hABCD);
    chk("w16_pready", {31'd0, s2rdy}, 32'd1);
    xfer(1, 8'h10, 1'b0, 32'h0, 4'hF, 0);
    chk("r16_rmask", {16'd0, s1rm}, 32'hFFFF);
    chk("r16_prdata", s2prd, 32'h00001357);

    repeat (3) @(negedge clk);
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
